// File: rtl/pll_lock_supervisor.sv
// Multi-PLL lock supervisor: holds PLLs in reset, waits for stable lock, releases
// domain resets in order, re-resets on lock loss and latches a fault after MAX_RETRY.
module pll_lock_supervisor #(
  parameter int unsigned N_PLL           = 2,
  parameter int unsigned RST_PULSE_CYC   = 8,
  parameter int unsigned LOCK_STABLE_CYC = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1000,
  parameter int unsigned RELEASE_GAP     = 4,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [N_PLL-1:0] locked_in,
  output logic [N_PLL-1:0] pll_rst,
  output logic [N_PLL-1:0] domain_rst,
  output logic             all_locked,
  output logic             fault,
  output logic [3:0]       retry_cnt,
  output logic [7:0]       loss_cnt
);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  localparam int unsigned PW       = $clog2(RST_PULSE_CYC + 1);
  localparam int unsigned SW       = $clog2(LOCK_STABLE_CYC + 2);
  localparam int unsigned TW       = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned REL_LAST = RELEASE_GAP * (N_PLL - 1);
  localparam int unsigned RW       = $clog2(REL_LAST + 2);

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYC - 1);
  localparam logic [SW-1:0] STABLE_DONE  = SW'(LOCK_STABLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] REL_DONE     = RW'(REL_LAST);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

  logic [N_PLL-1:0] sync_q, sync_d;
  logic [N_PLL-1:0] lk_q, lk_d;
  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic [TW-1:0]    timeout_q, timeout_d;
  logic [RW-1:0]    rel_q, rel_d;
  logic             pll_rst_q, pll_rst_d;
  logic [N_PLL-1:0] domain_rst_q, domain_rst_d;
  logic             all_locked_q, all_locked_d;
  logic             fault_q, fault_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             all_lk;
  logic             retry_path;

  assign all_lk = &lk_q;

  // Next-state and next-output computation for the bring-up sequencer.
  always_comb begin
    sync_d       = locked_in;
    lk_d         = sync_q;
    state_d      = state_q;
    pulse_d      = '0;
    stable_d     = '0;
    timeout_d    = '0;
    rel_d        = '0;
    pll_rst_d    = pll_rst_q;
    domain_rst_d = domain_rst_q;
    all_locked_d = all_locked_q;
    fault_d      = fault_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    retry_path   = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        pll_rst_d    = 1'b1;
        domain_rst_d = '1;
        if (pulse_q == PULSE_LAST) begin
          state_d   = ST_WAIT_LOCK;
          pll_rst_d = 1'b0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        stable_d  = all_lk ? (stable_q + 1'b1) : '0;
        timeout_d = timeout_q + 1'b1;
        // Stable lock takes priority over a simultaneous timeout.
        if (stable_q == STABLE_DONE) begin
          state_d         = ST_RELEASE;
          domain_rst_d[0] = 1'b0;
          stable_d        = '0;
          timeout_d       = '0;
        end else if (timeout_q == TIMEOUT_LAST) begin
          retry_path = 1'b1;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_RELEASE: begin
        rel_d = rel_q + 1'b1;
        if (!all_lk) begin
          retry_path = 1'b1;
        end else if (rel_q == REL_DONE) begin
          state_d      = ST_RUN;
          all_locked_d = 1'b1;
          retry_d      = 4'd0;
        end else begin
          for (int k = 1; k < int'(N_PLL); k++) begin
            if (rel_d == RW'(RELEASE_GAP * k)) begin
              domain_rst_d[k] = 1'b0;
            end else begin
              domain_rst_d[k] = domain_rst_q[k];
            end
          end
        end
      end
      ST_RUN: begin
        if (!all_lk) begin
          retry_path = 1'b1;
          loss_d     = (loss_q == 8'hFF) ? 8'hFF : (loss_q + 8'd1);
        end else begin
          all_locked_d = 1'b1;
        end
      end
      ST_FAULT: begin
        pll_rst_d    = 1'b1;
        domain_rst_d = '1;
        all_locked_d = 1'b0;
        fault_d      = 1'b1;
      end
      default: begin
        state_d      = ST_FAULT;
        pll_rst_d    = 1'b1;
        domain_rst_d = '1;
        all_locked_d = 1'b0;
        fault_d      = 1'b1;
      end
    endcase

    if (retry_path) begin
      pll_rst_d    = 1'b1;
      domain_rst_d = '1;
      all_locked_d = 1'b0;
      if (retry_q == RETRY_LIMIT) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = ST_PLL_RST;
        retry_d = retry_q + 4'd1;
      end
    end else begin
      retry_path = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q       <= '0;
      lk_q         <= '0;
      state_q      <= ST_PLL_RST;
      pulse_q      <= '0;
      stable_q     <= '0;
      timeout_q    <= '0;
      rel_q        <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      all_locked_q <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= 4'd0;
      loss_q       <= 8'd0;
    end else begin
      sync_q       <= sync_d;
      lk_q         <= lk_d;
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      stable_q     <= stable_d;
      timeout_q    <= timeout_d;
      rel_q        <= rel_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      all_locked_q <= all_locked_d;
      fault_q      <= fault_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
    end
  end

  assign pll_rst    = {N_PLL{pll_rst_q}};
  assign domain_rst = domain_rst_q;
  assign all_locked = all_locked_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: bring-up, glitch, lock loss, mid-release
// loss, timeout-to-fault and reset recovery, with hand-computed cycle positions.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst;
  logic [1:0] locked_in;
  logic [1:0] pll_rst;
  logic [1:0] domain_rst;
  logic       all_locked;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int err_cnt;
  int chk_cnt;

  pll_lock_supervisor #(
    .N_PLL(2), .RST_PULSE_CYC(8), .LOCK_STABLE_CYC(16),
    .LOCK_TIMEOUT(1000), .RELEASE_GAP(4), .MAX_RETRY(3)
  ) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .pll_rst(pll_rst),
    .domain_rst(domain_rst), .all_locked(all_locked), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_rst"},    32'(pll_rst),    32'h3);
    check_eq({tag, "_domain_rst"}, 32'(domain_rst), 32'h3);
    check_eq({tag, "_all_locked"}, 32'(all_locked), 32'h0);
    check_eq({tag, "_fault"},      32'(fault),      32'h0);
    check_eq({tag, "_retry"},      32'(retry_cnt),  32'h0);
    check_eq({tag, "_loss"},       32'(loss_cnt),   32'h0);
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    rst       = 1'b1;
    locked_in = 2'b00;
    tick(3);
    check_reset_vals("rst_hold");

    // Clean bring-up: cycle numbers count negedges after rst is released.
    rst = 1'b0;
    tick(7);  check_eq("up_pll_rst_c7", 32'(pll_rst), 32'h3);
    tick(1);  check_eq("up_pll_rst_c8", 32'(pll_rst), 32'h0);
    tick(12); locked_in = 2'b11;
    tick(18); check_eq("up_dr_c38", 32'(domain_rst), 32'h3);
    tick(1);  check_eq("up_dr_c39", 32'(domain_rst), 32'h2);
    tick(3);  check_eq("up_dr_c42", 32'(domain_rst), 32'h2);
    tick(1);  check_eq("up_dr_c43", 32'(domain_rst), 32'h0);
              check_eq("up_al_c43", 32'(all_locked), 32'h0);
    tick(1);  check_eq("up_al_c44", 32'(all_locked), 32'h1);
              check_eq("up_retry",  32'(retry_cnt),  32'h0);
              check_eq("up_pll_rst_run", 32'(pll_rst), 32'h0);

    // Loss in RUN: reaction three cycles after the pin drops.
    tick(2);  locked_in = 2'b10;
    tick(2);  check_eq("loss_al_c2", 32'(all_locked), 32'h1);
    tick(1);  check_eq("loss_dr",    32'(domain_rst), 32'h3);
              check_eq("loss_al",    32'(all_locked), 32'h0);
              check_eq("loss_pll",   32'(pll_rst),    32'h3);
              check_eq("loss_cnt",   32'(loss_cnt),   32'h1);
              check_eq("loss_retry", 32'(retry_cnt),  32'h1);
    locked_in = 2'b11;
    tick(24); check_eq("rerel_dr_c24", 32'(domain_rst), 32'h3);
    tick(1);  check_eq("rerel_dr_c25", 32'(domain_rst), 32'h2);
    tick(5);  check_eq("rerel_al",    32'(all_locked), 32'h1);
              check_eq("rerel_retry", 32'(retry_cnt),  32'h0);
              check_eq("rerel_dr",    32'(domain_rst), 32'h0);
              check_eq("rerel_loss",  32'(loss_cnt),   32'h1);

    // rst pulse during RUN, locks kept high.
    tick(2);  rst = 1'b1;
    tick(1);  check_reset_vals("rst_run");
    rst = 1'b0;
    tick(7);  check_eq("rst_run_pll_c7", 32'(pll_rst), 32'h3);
    tick(1);  check_eq("rst_run_pll_c8", 32'(pll_rst), 32'h0);

    // Glitch on locked_in[1] while the stable counter is at 10.
    tick(8);  locked_in = 2'b01;
    tick(1);  locked_in = 2'b11;
    tick(18); check_eq("glitch_dr_c18",  32'(domain_rst), 32'h3);
              check_eq("glitch_retry",   32'(retry_cnt),  32'h0);
              check_eq("glitch_pll",     32'(pll_rst),    32'h0);
    tick(1);  check_eq("glitch_dr_c19",  32'(domain_rst), 32'h2);

    // Lock loss during RELEASE, landing on the cycle domain_rst[1] would clear.
    tick(1);  locked_in = 2'b10;
    tick(2);  check_eq("midrel_dr_pre",  32'(domain_rst), 32'h2);
              check_eq("midrel_pll_pre", 32'(pll_rst),    32'h0);
    tick(1);  check_eq("midrel_dr",      32'(domain_rst), 32'h3);
              check_eq("midrel_pll",     32'(pll_rst),    32'h3);
              check_eq("midrel_retry",   32'(retry_cnt),  32'h1);
              check_eq("midrel_loss",    32'(loss_cnt),   32'h0);
              check_eq("midrel_al",      32'(all_locked), 32'h0);

    // Timeout to fault with locks held low.
    rst = 1'b1; locked_in = 2'b00;
    tick(2);  rst = 1'b0;
    tick(1007); check_eq("to_retry_c1007", 32'(retry_cnt), 32'h0);
                check_eq("to_pll_c1007",   32'(pll_rst),   32'h0);
    tick(1);    check_eq("to_retry_c1008", 32'(retry_cnt), 32'h1);
                check_eq("to_pll_c1008",   32'(pll_rst),   32'h3);
    tick(1007); check_eq("to_retry_c2015", 32'(retry_cnt), 32'h1);
    tick(1);    check_eq("to_retry_c2016", 32'(retry_cnt), 32'h2);
    tick(1008); check_eq("to_retry_c3024", 32'(retry_cnt), 32'h3);
    tick(1007); check_eq("to_fault_c4031", 32'(fault),     32'h0);
                check_eq("to_pll_c4031",   32'(pll_rst),   32'h0);
    tick(1);    check_eq("to_fault_c4032", 32'(fault),     32'h1);
                check_eq("to_pll_c4032",   32'(pll_rst),   32'h3);
                check_eq("to_dr_c4032",    32'(domain_rst), 32'h3);
                check_eq("to_retry_c4032", 32'(retry_cnt), 32'h3);
    locked_in = 2'b11;
    tick(40);   check_eq("fault_hold",     32'(fault),     32'h1);
                check_eq("fault_hold_pll", 32'(pll_rst),   32'h3);
                check_eq("fault_hold_dr",  32'(domain_rst), 32'h3);
                check_eq("fault_hold_al",  32'(all_locked), 32'h0);
    rst = 1'b1;
    tick(1);    check_reset_vals("fault_clr");
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
